// File: rtl/banco_pkg.sv
// Shared constants and helpers for the 8-entry register bank and its write-address decoder.
package banco_pkg;

  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned ANCHO_DEF = 8;

  // True when the write-enable vector has two or more bits set (illegal multi-hot write).
  function automatic logic es_multi(input logic [NUM_REGS-1:0] we);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we[i]) n++;
    end
    return logic'(n >= 2);
  endfunction

endpackage

// File: rtl/banco_registros_registro.sv
// Single ANCHO-bit storage register with asynchronous active-high reset and write enable.
module registro #(
  parameter int unsigned ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [ANCHO-1:0] d_i,
  output logic [ANCHO-1:0] q_o
);

  logic [ANCHO-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/banco_registros.sv
// 8-entry register bank fed by a one-hot write enable, with two registered read ports,
// same-edge write-to-read bypass, multi-hot error flag and per-entry written tracking.
module banco_registros
  import banco_pkg::*;
#(
  parameter int unsigned ANCHO         = ANCHO_DEF,
  parameter bit          REG_CERO_FIJO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] we,
  input  logic [ANCHO-1:0]    w_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   r_addr_a,
  input  logic [ADDR_W-1:0]   r_addr_b,
  output logic [ANCHO-1:0]    r_data_a,
  output logic [ANCHO-1:0]    r_data_b,
  output logic                r_valid,
  output logic [NUM_REGS-1:0] escrito,
  output logic                err_multi
);

  logic [ANCHO-1:0]    regs [NUM_REGS];
  logic                multi;
  logic [NUM_REGS-1:0] we_ok;

  logic [ANCHO-1:0]    byp_a, byp_b;
  logic [ANCHO-1:0]    r_data_a_d, r_data_a_q;
  logic [ANCHO-1:0]    r_data_b_d, r_data_b_q;
  logic                r_valid_d, r_valid_q;
  logic [NUM_REGS-1:0] escrito_d, escrito_q;
  logic                err_multi_d, err_multi_q;

  // we_ok is the effective per-entry write strobe: only legal one-hot writes, never entry 0
  // when it is hardwired.
  always_comb begin
    multi = es_multi(we);
    we_ok = '0;
    if ((we != '0) && !multi) we_ok = we;
    if (REG_CERO_FIJO) we_ok[0] = 1'b0;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    if (REG_CERO_FIJO && (i == 0)) begin : g_cero
      assign regs[i] = '0;
    end else begin : g_reg
      registro #(
        .ANCHO(ANCHO)
      ) u_registro (
        .clk  (clk),
        .rst  (rst),
        .en_i (we_ok[i]),
        .d_i  (w_data),
        .q_o  (regs[i])
      );
    end
  end

  // A hardwired entry 0 is never strobed and always reads 0, so bypass needs no special case.
  always_comb begin
    byp_a = regs[r_addr_a];
    if (we_ok[r_addr_a]) byp_a = w_data;
    byp_b = regs[r_addr_b];
    if (we_ok[r_addr_b]) byp_b = w_data;
  end

  always_comb begin
    r_data_a_d  = r_data_a_q;
    r_data_b_d  = r_data_b_q;
    r_valid_d   = rd_en;
    escrito_d   = escrito_q | we_ok;
    err_multi_d = err_multi_q | multi;
    if (rd_en) begin
      r_data_a_d = byp_a;
      r_data_b_d = byp_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_a_q  <= '0;
      r_data_b_q  <= '0;
      r_valid_q   <= 1'b0;
      escrito_q   <= '0;
      err_multi_q <= 1'b0;
    end else begin
      r_data_a_q  <= r_data_a_d;
      r_data_b_q  <= r_data_b_d;
      r_valid_q   <= r_valid_d;
      escrito_q   <= escrito_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign r_data_a  = r_data_a_q;
  assign r_data_b  = r_data_b_q;
  assign r_valid   = r_valid_q;
  assign escrito   = escrito_q;
  assign err_multi = err_multi_q;

endmodule
